// File: rtl/gs_iter_ctrl_if.sv
// Bundle of the divider request/result signals and the shared-multiplier
// handshake used by gs_iter_ctrl.
//   slave  : the division controller itself
//   master : the environment (requester plus the shared 24x24 multiplier)
interface gs_iter_ctrl_if;
   // division request
   logic        start;
   logic [23:0] n_in;
   logic [23:0] d_in;
   // shared multiplier handshake
   logic [23:0] mul_a;
   logic [23:0] mul_b;
   logic        mul_issue;
   logic        mul_ready;
   logic        mul_done;
   logic [47:0] mul_product;
   // division result
   logic        busy;
   logic        done;
   logic        err;
   logic [23:0] quotient;

   modport slave (
      input  start, n_in, d_in, mul_ready, mul_done, mul_product,
      output mul_a, mul_b, mul_issue, busy, done, err, quotient
   );

   modport master (
      output start, n_in, d_in, mul_ready, mul_done, mul_product,
      input  mul_a, mul_b, mul_issue, busy, done, err, quotient
   );
endinterface

// File: rtl/gs_iter_ctrl.sv
// Goldschmidt division controller. Computes N/D for Q1.23 mantissas with
// D in [0.5, 1) by running ITERS rounds of N*=F, D*=F, F=2-D on an external
// shared 24x24 multiplier (two back-to-back issues per round, results return
// in issue order). The final N is the quotient.
// Configuration macro GS_ROUND_EN: when defined, each product is reduced to
// Q1.23 with round-half-up (saturating); otherwise it is truncated.
module gs_iter_ctrl #(
   parameter int unsigned ITERS = 4
) (
   input  logic          clk,
   input  logic          clear_b,
   gs_iter_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      ISSUE_N,
      ISSUE_D,
      WAIT,
      UPDATE,
      FIN
   } state_t;

   state_t      state_reg;
   state_t      state_next;

   logic [23:0] n_reg;
   logic [23:0] d_reg;
   logic [23:0] f_reg;
   logic [23:0] n_prod_reg;
   logic [23:0] d_prod_reg;
   logic        prod_sel_reg;   // 0: next product belongs to N, 1: to D
   logic [3:0]  iter_reg;
   logic [23:0] quotient_reg;
   logic        err_reg;

   logic [23:0] prod_red;
   logic        d_bad;
   logic        last_iter;
   logic        unused_bits;

   // Divisor must be normalised into [0.5, 1): bit 23 clear, bit 22 set.
   assign d_bad     = d_reg[23] | ~d_reg[22];
   assign last_iter = ((iter_reg + 4'd1) == 4'(ITERS));

`ifdef GS_ROUND_EN
   logic [24:0] round_sum;

   // Round-half-up reduction of the Q2.46 product to Q1.23, saturating.
   always_comb begin
      round_sum = {1'b0, bus.mul_product[46:23]} + {24'd0, bus.mul_product[22]};
      prod_red  = round_sum[24] ? 24'hFFFFFF : round_sum[23:0];
   end

   // Bit 47 is always zero for legal operands; low bits only feed rounding.
   assign unused_bits = ^{bus.mul_product[47], bus.mul_product[21:0]};
`else
   // Truncating reduction of the Q2.46 product to Q1.23.
   always_comb begin
      prod_red = bus.mul_product[46:23];
   end

   // Bit 47 is always zero for legal operands; low bits are truncated away.
   assign unused_bits = ^{bus.mul_product[47], bus.mul_product[22:0]};
`endif

   // State register; a low clear_b abandons any division in flight.
   always_ff @(posedge clk) begin
      if (!clear_b) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and multiplier operand drive.
   always_comb begin
      state_next    = state_reg;
      bus.mul_issue = 1'b0;
      bus.mul_a     = 24'd0;
      bus.mul_b     = 24'd0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               state_next = CHECK;
            end
         end
         CHECK: begin
            state_next = d_bad ? FIN : ISSUE_N;
         end
         ISSUE_N: begin
            bus.mul_issue = 1'b1;
            bus.mul_a     = n_reg;
            bus.mul_b     = f_reg;
            if (bus.mul_ready) begin
               state_next = ISSUE_D;
            end
         end
         ISSUE_D: begin
            bus.mul_issue = 1'b1;
            bus.mul_a     = d_reg;
            bus.mul_b     = f_reg;
            if (bus.mul_ready) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            // The D product is always the second one back.
            if (bus.mul_done && prod_sel_reg) begin
               state_next = UPDATE;
            end
         end
         UPDATE: begin
            state_next = last_iter ? FIN : ISSUE_N;
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: operand latch, F generation, product capture and result load.
   always_ff @(posedge clk) begin
      if (!clear_b) begin
         n_reg        <= 24'd0;
         d_reg        <= 24'd0;
         f_reg        <= 24'd0;
         n_prod_reg   <= 24'd0;
         d_prod_reg   <= 24'd0;
         prod_sel_reg <= 1'b0;
         iter_reg     <= 4'd0;
         quotient_reg <= 24'd0;
         err_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  n_reg <= bus.n_in;
                  d_reg <= bus.d_in;
               end
            end
            CHECK: begin
               iter_reg     <= 4'd0;
               prod_sel_reg <= 1'b0;
               // 2 - D in Q1.23 is the two's complement of D modulo 2^24.
               f_reg        <= 24'd0 - d_reg;
               if (d_bad) begin
                  quotient_reg <= 24'd0;
                  err_reg      <= 1'b1;
               end
            end
            ISSUE_D, WAIT: begin
               // The N product may already arrive while D is still stalled.
               if (bus.mul_done) begin
                  if (!prod_sel_reg) begin
                     n_prod_reg <= prod_red;
                  end else begin
                     d_prod_reg <= prod_red;
                  end
                  prod_sel_reg <= ~prod_sel_reg;
               end
            end
            UPDATE: begin
               n_reg    <= n_prod_reg;
               d_reg    <= d_prod_reg;
               f_reg    <= 24'd0 - d_prod_reg;
               iter_reg <= iter_reg + 4'd1;
               // Load the result on the way into FIN so it is valid with done.
               if (last_iter) begin
                  quotient_reg <= n_prod_reg;
                  err_reg      <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy     = (state_reg != IDLE) && (state_reg != FIN);
   assign bus.done     = (state_reg == FIN);
   assign bus.err      = (state_reg == FIN) && err_reg;
   assign bus.quotient = quotient_reg;

endmodule

// File: doc/gs_iter_ctrl.md
GS_ITER_CTRL -- requirements
Module: gs_iter_ctrl

Interface
REQ-001 The block SHALL have parameter ITERS, default 4, number of Goldschmidt iterations; legal range 1..8.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clear_b  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port start  input  1  one-cycle request to begin a division; sampled only in IDLE.
REQ-005 The block SHALL have port n_in  input  24  dividend mantissa, unsigned Q1.23; sampled with start.
REQ-006 The block SHALL have port d_in  input  24  divisor mantissa, unsigned Q1.23; legal range 24'h400000..24'h7FFFFF; sampled with start.
REQ-007 The block SHALL have port mul_a, mul_b  output  24 each  operands for the shared 24x24 multiplier.
REQ-008 The block SHALL have port mul_issue  output  1  operand-valid; held with stable operands until accepted.
REQ-009 The block SHALL have port mul_ready  input  1  multiplier accepts the operands when mul_issue and mul_ready are both high.
REQ-010 The block SHALL have port mul_done, mul_product  input  1, 48  returned result valid and unsigned Q2.46 product; results return in issue order.
REQ-011 The block SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-012 The block SHALL have port done, err  output  1 each  one-cycle completion pulse, and divisor-out-of-range flag valid with done.
REQ-013 The block SHALL have port quotient  output  24  Q1.23 result; held from done until the next accepted start.

Function
REQ-014 The states SHALL be IDLE, CHECK, ISSUE_N, ISSUE_D, WAIT, UPDATE, FIN.
REQ-015 In IDLE, start=1 SHALL latch n_in and d_in into N and D and go to CHECK; start SHALL be ignored in every other state.
REQ-016 CHECK: if D[23]=1 or D[22]=0, the block SHALL go to FIN with err=1 and quotient=0 and issue no multiplies; otherwise it SHALL compute F = (2^24 - D) mod 2^24 (i.e. 2-D), set iter=0 and go to ISSUE_N.
REQ-017 ISSUE_N SHALL drive mul_a=N, mul_b=F, mul_issue=1; on acceptance it SHALL go to ISSUE_D.
REQ-018 ISSUE_D SHALL drive mul_a=D, mul_b=F, mul_issue=1; on acceptance it SHALL go to WAIT (back-to-back issue; at most 2 outstanding).
REQ-019 WAIT SHALL capture the first mul_done as the N product and the second as the D product, then go to UPDATE; mul_done outside WAIT/ISSUE_D SHALL be ignored.
REQ-020 A product SHALL be reduced to Q1.23 as bits [46:23]; bit 47 is never set for legal operands and SHALL be discarded.
REQ-021 UPDATE SHALL write N and D with the reduced products, recompute F = 2-D and increment iter; if iter reaches ITERS it SHALL go to FIN, else to ISSUE_N.
REQ-022 FIN SHALL load quotient with N (or 0 on err), pulse done for exactly one cycle, drop busy in the same cycle and return to IDLE; start in FIN SHALL be ignored.
REQ-023 mul_issue SHALL be 0 in all states except ISSUE_N and ISSUE_D; a stalled mul_ready SHALL hold mul_a and mul_b unchanged.
REQ-024 Exactly 2*ITERS multiplier issues SHALL occur per legal division, and none for err.

Reset
REQ-025 With clear_b=0 at a rising edge, the block SHALL enter IDLE with busy=0, done=0, err=0, mul_issue=0, mul_a=0, mul_b=0, quotient=0, iter=0.
REQ-026 A reset mid-operation SHALL abandon the division; products returning after reset SHALL be ignored.

Configuration
REQ-027 With GS_ROUND_EN defined, reduction SHALL be round-half-up: bits [46:23] plus bit 22, saturating at 24'hFFFFFF.
REQ-028 Without GS_ROUND_EN, reduction SHALL be pure truncation of bits [46:23].

Verification
REQ-029 The bench SHALL cover: n_in=24'h600000, d_in=24'h400000, ITERS=4, mul_ready=1 -> done with err=0, quotient=24'hBFFF40 (both configurations), 8 issues counted.
REQ-030 The bench SHALL cover: n_in=d_in=24'h400000, ITERS=4 -> quotient=24'h7FFF80, err=0.
REQ-031 The bench SHALL cover: d_in=24'h800000, then separately d_in=24'h3FFFFF -> done, err=1, quotient=0, zero mul_issue cycles.
REQ-032 The bench SHALL cover: mul_ready low for 5 cycles during ISSUE_D -> mul_issue stays high, mul_a/mul_b stable, and the final quotient is unchanged versus REQ-029.
REQ-033 The bench SHALL cover: start pulsed while busy with different operands -> ignored, and the result matches the first operands.
REQ-034 The bench SHALL cover: clear_b low for one cycle during WAIT, then a new start (24'h600000/24'h400000) -> all outputs at reset values, late mul_done ignored, and the second run yields 24'hBFFF40.
